pixel_point_proc: RTL

PIXEL_POINT_PROC -- requirements
Module: pixel_point_proc

---
 rtl/pixel_proc_pkg.sv | 20 ++
 rtl/pixel_op_unit.sv | 62 ++++++
 rtl/pixel_point_proc.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pixel_proc_pkg.sv
// Shared encodings for the pixel point processor.
//   mode_t  : per-frame operation selected by cfg_mode
//   state_t : frame sequencer states
package pixel_proc_pkg;

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'd0,
      MODE_BRIGHT = 2'd1,
      MODE_INVERT = 2'd2,
      MODE_THRESH = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/pixel_op_unit.sv
// Combinational per-pixel point operation.
// Ports:
//   mode      : operation (bypass / brightness / invert / threshold)
//   sign      : brightness direction, 1 add, 0 subtract
//   value     : brightness offset
//   threshold : threshold level, gray strictly above it gives full scale
//   pix       : input pixel, channel k at [k*DW +: DW]
//   res       : processed pixel
module pixel_op_unit
   import pixel_proc_pkg::*;
#(
   parameter int DW = 8,
   parameter int CH = 3
) (
   input  mode_t            mode,
   input  logic             sign,
   input  logic [DW-1:0]    value,
   input  logic [DW-1:0]    threshold,
   input  logic [CH*DW-1:0] pix,
   output logic [CH*DW-1:0] res
);

   localparam int SW = DW + 2;
   localparam logic [SW-1:0] CH_DIV = SW'(CH);
   localparam logic [DW-1:0] MAXV = '1;

   logic [SW-1:0] sum;
   logic [DW-1:0] gray;
   logic [DW-1:0] inv_v;
   logic [DW-1:0] thr_v;

   // Up to four full-scale channels fit in DW+2 bits.
   always_comb begin
      sum = '0;
      for (int k = 0; k < CH; k++) begin
         sum = sum + SW'(pix[k*DW +: DW]);
      end
   end

   assign gray  = DW'(sum / CH_DIV);
   assign inv_v = MAXV - gray;
   assign thr_v = (gray > threshold) ? MAXV : '0;

   for (genvar k = 0; k < CH; k++) begin : g_ch
      logic [DW-1:0] chan;
      logic [DW:0]   add_w;
      logic [DW:0]   sub_w;
      logic [DW-1:0] bright;

      assign chan  = pix[k*DW +: DW];
      assign add_w = {1'b0, chan} + {1'b0, value};
      // MSB of the difference is the borrow: result went below zero.
      assign sub_w = {1'b0, chan} - {1'b0, value};
      assign bright = sign ? (add_w[DW] ? MAXV : add_w[DW-1:0])
                           : (sub_w[DW] ? '0   : sub_w[DW-1:0]);

      assign res[k*DW +: DW] = (mode == MODE_BRIGHT) ? bright :
                               (mode == MODE_INVERT) ? inv_v  :
                               (mode == MODE_THRESH) ? thr_v  : chan;
   end

endmodule

// File: rtl/pixel_point_proc.sv
// Frame-based pixel point processor with a 2-stage valid/ready pipeline.
// Ports:
//   HCLK, HRESET         : clock, async active-high reset
//   start                : frame start (IDLE only)
//   cfg_*                : operation config, captured at frame start
//   s_valid/s_ready/s_data : input pixel stream
//   m_valid/m_ready/m_data : output pixel stream
//   m_sol/m_eol/m_eof    : output position tags (col 0, col WIDTH-1, last)
//   busy                 : not IDLE
//   done                 : one-cycle frame completion pulse
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for start, input stalled
// ST_RUN   | accepting WIDTH*HEIGHT pixels
// ST_FLUSH | all pixels accepted, draining the pipeline
// ST_DONE  | one-cycle done pulse, then back to IDLE
module pixel_point_proc
   import pixel_proc_pkg::*;
#(
   parameter int WIDTH  = 768,
   parameter int HEIGHT = 512,
   parameter int DW     = 8,
   parameter int CH     = 3
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             start,
   input  logic [1:0]       cfg_mode,
   input  logic             cfg_sign,
   input  logic [DW-1:0]    cfg_value,
   input  logic [DW-1:0]    cfg_threshold,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [CH*DW-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [CH*DW-1:0] m_data,
   output logic             m_sol,
   output logic             m_eol,
   output logic             m_eof,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

   state_t state_q, state_d;

   mode_t         mode_q;
   logic          sign_q;
   logic [DW-1:0] value_q;
   logic [DW-1:0] thr_q;

   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;

   logic             s1_valid;
   logic [CH*DW-1:0] s1_data;
   logic             s1_sol, s1_eol, s1_eof;
   logic [CH*DW-1:0] op_res;

   logic adv2, ld1, accept, launch, col_last, last_px;

   assign adv2     = !m_valid || m_ready;
   assign ld1      = adv2 || !s1_valid;
   assign s_ready  = (state_q == ST_RUN) && ld1;
   assign accept   = s_valid && s_ready;
   assign launch   = (state_q == ST_IDLE) && start;
   assign col_last = (col_q == COL_LAST);
   assign last_px  = col_last && (row_q == ROW_LAST);
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN:   if (accept && last_px) state_d = ST_FLUSH;
         ST_FLUSH: if (!s1_valid && !m_valid) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         mode_q  <= MODE_BYPASS;
         sign_q  <= 1'b0;
         value_q <= '0;
         thr_q   <= '0;
      end else if (launch) begin
         mode_q  <= mode_t'(cfg_mode);
         sign_q  <= cfg_sign;
         value_q <= cfg_value;
         thr_q   <= cfg_threshold;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         col_q <= '0;
         row_q <= '0;
      end else if (launch) begin
         col_q <= '0;
         row_q <= '0;
      end else if (accept) begin
         if (col_last) begin
            col_q <= '0;
            row_q <= last_px ? '0 : row_q + RW'(1);
         end else begin
            col_q <= col_q + CW'(1);
         end
      end
   end

   pixel_op_unit #(.DW(DW), .CH(CH)) u_op (
      .mode      (mode_q),
      .sign      (sign_q),
      .value     (value_q),
      .threshold (thr_q),
      .pix       (s_data),
      .res       (op_res)
   );

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_sol   <= 1'b0;
         s1_eol   <= 1'b0;
         s1_eof   <= 1'b0;
      end else if (ld1) begin
         s1_valid <= accept;
         if (accept) begin
            s1_data <= op_res;
            s1_sol  <= (col_q == '0);
            s1_eol  <= col_last;
            s1_eof  <= last_px;
         end
      end
   end

   // Payload only moves with a valid pixel so it stays put across bubbles.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_sol   <= 1'b0;
         m_eol   <= 1'b0;
         m_eof   <= 1'b0;
      end else if (adv2) begin
         m_valid <= s1_valid;
         if (s1_valid) begin
            m_data <= s1_data;
            m_sol  <= s1_sol;
            m_eol  <= s1_eol;
            m_eof  <= s1_eof;
         end
      end
   end

endmodule
